// File: rtl/register_array_loader.sv
// Streams 3x3 convolution windows of a square feature map from SRAM into a
// register-array FIFO, one entry per cycle, inserting zero entries for padding.
module register_array_loader #(
   parameter int DW = 128,
   parameter int AW = 12
) (
   input  logic          SYS_CLK,
   input  logic          SYS_NRST,
   input  logic          start,
   input  logic [5:0]    pic_size,
   input  logic          padding,
   output logic          busy,
   output logic          done,
   output logic          sram_rd_en,
   output logic [AW-1:0] sram_rd_addr,
   input  logic [DW-1:0] sram_rd_data,
   output logic          register_array_write_enable,
   output logic [3:0]    register_array_write_addr_index,
   output logic [2:0]    register_array_write_addr_bit,
   output logic          register_array_write_rst,
   output logic [DW-1:0] register_array_write_data,
   output logic [3:0]    register_array_write_size,
   input  logic          register_array_full
);

   localparam int PW = (AW > 12) ? AW : 12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [5:0]    r_pic;
   logic          r_pad;
   logic [5:0]    r_o;
   logic [5:0]    r_row;
   logic [5:0]    r_col;
   logic [1:0]    r_i;
   logic [1:0]    r_j;
   logic [2:0]    r_slot;

   logic          r_s1_valid;
   logic          r_s1_pad;
   logic          r_s1_fresh;
   logic [3:0]    r_s1_index;
   logic [2:0]    r_s1_slot;
   logic [DW-1:0] r_hold;

   logic signed [7:0] w_o_calc;
   logic              w_o_nonpos;
   logic signed [7:0] w_y;
   logic signed [7:0] w_x;
   logic              w_elem_pad;
   logic [PW-1:0]     w_addr_full;
   logic [3:0]        w_index;
   logic              w_last;
   logic              w_accept;
   logic              w_issue;

   // Output window count, evaluated on the raw inputs so it can be latched on start
   assign w_o_calc   = $signed({2'b00, pic_size}) - 8'sd2 + (padding ? 8'sd2 : 8'sd0);
   assign w_o_nonpos = (w_o_calc <= 8'sd0);

   assign w_y = $signed({2'b00, r_row}) + $signed({6'b000000, r_i}) - $signed({7'b0000000, r_pad});
   assign w_x = $signed({2'b00, r_col}) + $signed({6'b000000, r_j}) - $signed({7'b0000000, r_pad});
   assign w_elem_pad = (w_y < 8'sd0) || (w_y >= $signed({2'b00, r_pic})) ||
                       (w_x < 8'sd0) || (w_x >= $signed({2'b00, r_pic}));
   assign w_addr_full = PW'(w_y[5:0]) * PW'(r_pic) + PW'(w_x[5:0]);
   assign w_index     = {2'b00, r_i} * 4'd3 + {2'b00, r_j};
   assign w_last      = (r_row == r_o - 6'd1) && (r_col == r_o - 6'd1) &&
                        (r_i == 2'd2) && (r_j == 2'd2);

   // Stage 0 may issue only into an empty or draining stage 1
   assign w_accept = r_s1_valid && !register_array_full;
   assign w_issue  = (r_state == ST_RUN) && (!r_s1_valid || w_accept);

   assign sram_rd_en   = w_issue && !w_elem_pad;
   assign sram_rd_addr = sram_rd_en ? w_addr_full[AW-1:0] : '0;

   assign register_array_write_enable     = r_s1_valid;
   assign register_array_write_addr_index = r_s1_index;
   assign register_array_write_addr_bit   = r_s1_slot;
   assign register_array_write_rst        = r_s1_valid && r_s1_pad;
   assign register_array_write_data       = (!r_s1_valid || r_s1_pad) ? '0 :
                                            (r_s1_fresh ? sram_rd_data : r_hold);
   assign register_array_write_size       = 4'd9;

   always_ff @(posedge SYS_CLK) begin
      if (!SYS_NRST) r_state <= ST_IDLE;
      else           r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_state_next = w_o_nonpos ? ST_DONE : ST_RUN;
         ST_RUN:   if (w_issue && w_last) w_state_next = ST_DRAIN;
         ST_DRAIN: if (w_accept) w_state_next = ST_DONE;
         ST_DONE:  w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != ST_IDLE);
      done = (r_state == ST_DONE);
   end

   always_ff @(posedge SYS_CLK) begin
      if (!SYS_NRST) begin
         r_pic  <= '0;
         r_pad  <= 1'b0;
         r_o    <= '0;
         r_row  <= '0;
         r_col  <= '0;
         r_i    <= '0;
         r_j    <= '0;
         r_slot <= '0;
      end else begin
         if (r_state == ST_IDLE && start) begin
            r_pic  <= pic_size;
            r_pad  <= padding;
            r_o    <= w_o_calc[5:0];
            r_row  <= '0;
            r_col  <= '0;
            r_i    <= '0;
            r_j    <= '0;
            r_slot <= '0;
         end
         if (w_issue) begin
            if (r_j == 2'd2) begin
               r_j <= '0;
               if (r_i == 2'd2) begin
                  r_i    <= '0;
                  r_slot <= r_slot + 3'd1;
                  if (r_col == r_o - 6'd1) begin
                     r_col <= '0;
                     r_row <= r_row + 6'd1;
                  end else begin
                     r_col <= r_col + 6'd1;
                  end
               end else begin
                  r_i <= r_i + 2'd1;
               end
            end else begin
               r_j <= r_j + 2'd1;
            end
         end
      end
   end

   // Stage 1: fresh marks the cycle the SRAM word is on the bus; later stall
   // cycles replay it from r_hold.
   always_ff @(posedge SYS_CLK) begin
      if (!SYS_NRST) begin
         r_s1_valid <= 1'b0;
         r_s1_pad   <= 1'b0;
         r_s1_fresh <= 1'b0;
         r_s1_index <= '0;
         r_s1_slot  <= '0;
         r_hold     <= '0;
      end else begin
         if (r_s1_valid && r_s1_fresh) r_hold <= sram_rd_data;
         if (w_issue) begin
            r_s1_valid <= 1'b1;
            r_s1_pad   <= w_elem_pad;
            r_s1_fresh <= !w_elem_pad;
            r_s1_index <= w_index;
            r_s1_slot  <= r_slot;
         end else if (w_accept) begin
            r_s1_valid <= 1'b0;
            r_s1_fresh <= 1'b0;
         end else begin
            r_s1_fresh <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_register_array_loader.sv
// Directed bench for register_array_loader: SRAM model with one-cycle latency,
// negedge monitor logging reads, accepted writes and done pulses.
module tb_register_array_loader;

   logic         clk;
   logic         nrst;
   logic         start;
   logic [5:0]   pic_size;
   logic         padding;
   logic         busy;
   logic         done;
   logic         rd_en;
   logic [11:0]  rd_addr;
   logic [127:0] rd_data;
   logic         we;
   logic [3:0]   w_idx;
   logic [2:0]   w_bit;
   logic         w_rst;
   logic [127:0] w_data;
   logic [3:0]   w_size;
   logic         full;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int base = 0;

   int           rd_addr_q[$];
   int           rd_cyc_q[$];
   int           wr_idx_q[$];
   int           wr_bit_q[$];
   int           wr_rst_q[$];
   int           wr_cyc_q[$];
   logic [127:0] wr_data_q[$];
   int           done_q[$];

   register_array_loader #(.DW(128), .AW(12)) dut (
      .SYS_CLK                         (clk),
      .SYS_NRST                        (nrst),
      .start                           (start),
      .pic_size                        (pic_size),
      .padding                         (padding),
      .busy                            (busy),
      .done                            (done),
      .sram_rd_en                      (rd_en),
      .sram_rd_addr                    (rd_addr),
      .sram_rd_data                    (rd_data),
      .register_array_write_enable     (we),
      .register_array_write_addr_index (w_idx),
      .register_array_write_addr_bit   (w_bit),
      .register_array_write_rst        (w_rst),
      .register_array_write_data       (w_data),
      .register_array_write_size       (w_size),
      .register_array_full             (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic logic [127:0] dat(input int a);
      return {4{32'hD000_0000 + 32'(a)}};
   endfunction

   // Non-read cycles drive junk so a lost holding register shows up
   always @(posedge clk) begin
      if (rd_en) rd_data <= dat(int'(rd_addr));
      else       rd_data <= {$urandom, $urandom, $urandom, $urandom};
   end

   always @(negedge clk) begin
      if (rd_en) begin
         rd_addr_q.push_back(int'(rd_addr));
         rd_cyc_q.push_back(cyc - base);
      end
      if (we && !full) begin
         wr_idx_q.push_back(int'(w_idx));
         wr_bit_q.push_back(int'(w_bit));
         wr_rst_q.push_back(int'(w_rst));
         wr_cyc_q.push_back(cyc - base);
         wr_data_q.push_back(w_data);
      end
      if (done) done_q.push_back(cyc - base);
   end

   function automatic int qi(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   function automatic logic [127:0] qd(input logic [127:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 128'hx;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      rd_addr_q.delete(); rd_cyc_q.delete();
      wr_idx_q.delete();  wr_bit_q.delete(); wr_rst_q.delete();
      wr_cyc_q.delete();  wr_data_q.delete(); done_q.delete();
   endtask

   // Cycle 0 is the cycle start is high; returns early in cycle 1
   task automatic load(input int ps, input logic pad);
      tick();
      clear_logs();
      base = cyc;
      start = 1'b1;
      pic_size = 6'(ps);
      padding = pad;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      for (int k = 0; k < limit && done_q.size() == 0; k++) @(negedge clk);
      tick();
   endtask

   int rst_exp[9]  = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
   int addr_exp[9] = '{0, 0, 0, 0, 0, 1, 0, 3, 4};
   int p4_exp[9]   = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

   initial begin
      nrst = 1'b0; start = 1'b0; pic_size = '0; padding = 1'b0; full = 1'b0;
      rd_data = '0;
      repeat (3) tick();
      check("rst_busy",  128'(busy),    128'(0));
      check("rst_done",  128'(done),    128'(0));
      check("rst_rd_en", 128'(rd_en),   128'(0));
      check("rst_addr",  128'(rd_addr), 128'(0));
      check("rst_we",    128'(we),      128'(0));
      check("rst_wrst",  128'(w_rst),   128'(0));
      check("rst_idx",   128'(w_idx),   128'(0));
      check("rst_bit",   128'(w_bit),   128'(0));
      check("rst_data",  w_data,        128'(0));
      check("rst_size",  128'(w_size),  128'(9));
      nrst = 1'b1;

      // 3x3, no padding: one window
      load(3, 1'b0);
      wait_done(40);
      check("t1_nrd", 128'(rd_addr_q.size()), 128'(9));
      check("t1_nwr", 128'(wr_idx_q.size()),  128'(9));
      for (int k = 0; k < 9; k++) begin
         check($sformatf("t1_rdaddr%0d", k), 128'(qi(rd_addr_q, k)), 128'(k));
         check($sformatf("t1_rdcyc%0d", k),  128'(qi(rd_cyc_q, k)),  128'(k + 1));
         check($sformatf("t1_wridx%0d", k),  128'(qi(wr_idx_q, k)),  128'(k));
         check($sformatf("t1_wrcyc%0d", k),  128'(qi(wr_cyc_q, k)),  128'(k + 2));
         check($sformatf("t1_wrbit%0d", k),  128'(qi(wr_bit_q, k)),  128'(0));
         check($sformatf("t1_wrdat%0d", k),  qd(wr_data_q, k),       dat(k));
      end
      check("t1_done_cyc", 128'(qi(done_q, 0)), 128'(11));
      check("t1_busy_end", 128'(busy), 128'(0));

      // 3x3 with padding: nine windows, 49 real pixels
      load(3, 1'b1);
      wait_done(200);
      check("t2_nwr", 128'(wr_idx_q.size()),  128'(81));
      check("t2_nrd", 128'(rd_addr_q.size()), 128'(49));
      for (int k = 0; k < 9; k++) begin
         check($sformatf("t2_w0idx%0d", k), 128'(qi(wr_idx_q, k)), 128'(k));
         check($sformatf("t2_w0rst%0d", k), 128'(qi(wr_rst_q, k)), 128'(rst_exp[k]));
         check($sformatf("t2_w0dat%0d", k), qd(wr_data_q, k),
               rst_exp[k] == 1 ? 128'(0) : dat(addr_exp[k]));
      end
      check("t2_w7_slot", 128'(qi(wr_bit_q, 63)), 128'(7));
      check("t2_w8_slot", 128'(qi(wr_bit_q, 80)), 128'(0));
      check("t2_done_cyc", 128'(qi(done_q, 0)), 128'(83));

      // Full held five cycles while index 4 waits
      load(3, 1'b0);
      repeat (5) tick();
      full = 1'b1;
      repeat (4) tick();
      check("t3_hold_we",  128'(we),    128'(1));
      check("t3_hold_idx", 128'(w_idx), 128'(4));
      check("t3_hold_dat", w_data,      dat(4));
      tick();
      full = 1'b0;
      wait_done(60);
      check("t3_nwr", 128'(wr_idx_q.size()),  128'(9));
      check("t3_nrd", 128'(rd_addr_q.size()), 128'(9));
      check("t3_idx4_cyc", 128'(qi(wr_cyc_q, 4)), 128'(11));
      check("t3_idx4_dat", qd(wr_data_q, 4), dat(4));
      check("t3_rd5_cyc",  128'(qi(rd_cyc_q, 5)), 128'(11));
      check("t3_idx8_dat", qd(wr_data_q, 8), dat(8));
      check("t3_done_cyc", 128'(qi(done_q, 0)), 128'(16));

      // Too small for any window
      load(2, 1'b0);
      check("t4_busy", 128'(busy), 128'(1));
      check("t4_done", 128'(done), 128'(1));
      wait_done(10);
      check("t4_done_cyc", 128'(qi(done_q, 0)), 128'(1));
      check("t4_nrd", 128'(rd_addr_q.size()), 128'(0));
      check("t4_nwr", 128'(wr_idx_q.size()),  128'(0));

      // Reset mid-run, then a 4x4 load with an ignored start in the middle
      load(3, 1'b1);
      repeat (20) tick();
      nrst = 1'b0;
      tick();
      check("t5_rst_busy",  128'(busy),    128'(0));
      check("t5_rst_rden",  128'(rd_en),   128'(0));
      check("t5_rst_we",    128'(we),      128'(0));
      check("t5_rst_idx",   128'(w_idx),   128'(0));
      check("t5_rst_bit",   128'(w_bit),   128'(0));
      check("t5_rst_data",  w_data,        128'(0));
      check("t5_rst_size",  128'(w_size),  128'(9));
      nrst = 1'b1;
      load(4, 1'b0);
      repeat (3) tick();
      start = 1'b1; pic_size = 6'd5; padding = 1'b1;
      tick();
      start = 1'b0;
      wait_done(100);
      repeat (5) tick();
      for (int k = 0; k < 9; k++)
         check($sformatf("t5_rdaddr%0d", k), 128'(qi(rd_addr_q, k)), 128'(p4_exp[k]));
      check("t5_first_idx", 128'(qi(wr_idx_q, 0)), 128'(0));
      check("t5_first_bit", 128'(qi(wr_bit_q, 0)), 128'(0));
      check("t5_first_dat", qd(wr_data_q, 0), dat(0));
      check("t5_nwr", 128'(wr_idx_q.size()),  128'(36));
      check("t5_nrd", 128'(rd_addr_q.size()), 128'(36));
      check("t5_w3_slot", 128'(qi(wr_bit_q, 35)), 128'(3));
      check("t5_ndone", 128'(done_q.size()), 128'(1));
      check("t5_done_cyc", 128'(qi(done_q, 0)), 128'(38));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/register_array_loader.md
REGISTER_ARRAY_LOADER -- requirements
Module: register_array_loader

Interface
REQ-001 Parameter DW, default 128, SHALL set the data width of one SRAM word and one register-array entry.
REQ-002 Parameter AW, default 12, SHALL set the SRAM read-address width, covering 63*63 words.
REQ-003 SYS_CLK  in  1  SHALL be the single clock; all logic SHALL be on its rising edge.
REQ-004 SYS_NRST  in  1  SHALL be a synchronous, active-low reset.
REQ-005 start  in  1  SHALL be a one-cycle request to load one feature map; it SHALL be honoured only in IDLE.
REQ-006 pic_size  in  6  SHALL be the square image edge length, sampled on the accepted start.
REQ-007 padding  in  1  SHALL select one-pixel zero padding, sampled on the accepted start.
REQ-008 busy  out  1  SHALL be high in every state except IDLE.
REQ-009 done  out  1  SHALL be a one-cycle completion pulse.
REQ-010 sram_rd_en  out  1  SHALL be the SRAM read strobe, with data returned the next cycle.
REQ-011 sram_rd_addr  out  AW  SHALL be the SRAM word address.
REQ-012 sram_rd_data  in  DW  SHALL be the SRAM read data, valid one cycle after sram_rd_en.
REQ-013 register_array_write_enable  out  1  SHALL be the entry-write strobe to the register-array FIFO.
REQ-014 register_array_write_addr_index  out  4  SHALL be the window element index, 0..8.
REQ-015 register_array_write_addr_bit  out  3  SHALL be the FIFO slot, 0..7.
REQ-016 register_array_write_rst  out  1  SHALL mark a zero (padding) entry.
REQ-017 register_array_write_data  out  DW  SHALL be the entry data.
REQ-018 register_array_write_size  out  4  SHALL be the constant 9.
REQ-019 register_array_full  in  1  SHALL be the FIFO full flag; a write presented while it is high is not accepted.

Function
REQ-020 The block SHALL use the states IDLE, RUN, DRAIN and DONE: IDLE->RUN on start; RUN->DRAIN after the last element is issued; DRAIN->DONE when the last write is accepted; DONE->IDLE unconditionally after one cycle.
REQ-021 The output window count SHALL be O = pic_size - 2 + 2*padding, computed signed; if O <= 0, start SHALL go IDLE->DONE with no reads or writes.
REQ-022 Windows SHALL be scanned in raster order r = 0..O-1, c = 0..O-1; elements within a window SHALL be scanned i = 0..2, j = 0..2, with index = 3i + j.
REQ-023 Image coordinates SHALL be y = r + i - padding and x = c + j - padding.
REQ-024 An element SHALL be a pad when y or x < 0 or >= pic_size; a pad SHALL issue no SRAM read.
REQ-025 A non-pad element SHALL issue sram_rd_en with sram_rd_addr = y*pic_size + x, computed at full width without truncation below AW.
REQ-026 Stage 0 (issue) and stage 1 (write) SHALL form a two-stage pipeline: an element issued in cycle t SHALL present its write in cycle t+1.
REQ-027 In stage 1, write_data SHALL be sram_rd_data (captured into a holding register on return) for a non-pad, or 0 with write_rst = 1 for a pad.
REQ-028 write_addr_bit SHALL equal the window ordinal mod 8; it SHALL wrap 7->0 and advance only after index 8 of a window is accepted.
REQ-029 A write SHALL be accepted when write_enable = 1 and full = 0.
REQ-030 While full = 1, stage 1 SHALL hold its index, slot, rst and data stable, and stage 0 SHALL issue nothing; stage 0 SHALL issue only when stage 1 is empty or accepting in that cycle.
REQ-031 The held data register SHALL guarantee no SRAM data is lost during a stall.
REQ-032 Throughput SHALL be one entry per cycle when not full: 9*O*O + 1 cycles from the first issue to the last write.
REQ-033 done SHALL pulse in the DONE cycle, one cycle after the last accepted write.
REQ-034 start asserted while busy SHALL be ignored, with no change to the latched configuration.

Reset
REQ-035 On SYS_NRST = 0 at a clock edge, the state SHALL go to IDLE, and busy, done, sram_rd_en, write_enable, write_rst, write_addr_index, write_addr_bit and sram_rd_addr SHALL go to 0.
REQ-036 Also on reset, write_data, the pipeline valid bits and all counters SHALL clear.
REQ-037 A reset mid-run SHALL abort the load with no further reads or writes; write_size SHALL remain 9.

Verification
REQ-038 pic_size = 3, padding = 0, start in cycle 0, full = 0 -> reads at addresses 0..8 in cycles 1..9; writes of index 0..8 at slot 0 in cycles 2..10; done in cycle 11.
REQ-039 pic_size = 3, padding = 1 -> O = 3 with 9 windows.
- Window 0: indices 0,1,2,3,6 written with rst = 1; index 4 from address 0, 5 from 1, 7 from 3, 8 from 4.
- Window 8 SHALL use slot 0 (wrap).
REQ-040 full held high for 5 cycles while index 4 is pending -> index 4 is written once with unchanged data after full drops; no SRAM read is issued during the stall; the total is 9 writes.
REQ-041 pic_size = 2, padding = 0 -> done the cycle after start, zero reads and zero writes.
REQ-042 Reset asserted in mid-RUN, then start with pic_size = 4 -> the new run starts at window 0, slot 0, index 0, with reads 0,1,2,4,5,6,8,9,10 for window 0.
REQ-043 start pulsed during RUN -> ignored; the done count equals 1.
